// File: rtl/mips_pkg.sv
// Shared definitions for the multicycle MIPS front end: opcode values,
// instruction field positions and the fetch FSM state type.
package mips_pkg;

    // Instruction field positions
    localparam int OPC_MSB = 31;
    localparam int OPC_LSB = 26;
    localparam int IMM_MSB = 15;
    localparam int IMM_LSB = 0;

    // Opcodes the fetch stage has to recognise
    localparam logic [5:0] OPC_BEZ = 6'b101000;
    localparam logic [5:0] OPC_BNE = 6'b101001;
    localparam logic [5:0] OPC_JMP = 6'b101010;

    // Immediate value that makes a JMP target its own address
    localparam logic [15:0] IMM_SELF_JUMP = 16'hFFFF;

    // Fetch FSM states
    typedef enum logic [1:0] {
        ST_FETCH   = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_BR_WAIT = 2'd2
    } fetch_state_e;

    // True for the conditional branches that must wait for execute
    function automatic logic is_cond_branch(input logic [5:0] opc);
        return (opc == OPC_BEZ) || (opc == OPC_BNE);
    endfunction

endpackage

// File: rtl/branch_target_calc.sv
// PC-relative target adder: base + 4 + (sign-extended imm16 scaled to words).
// The word scaling keeps the two low bits of an aligned base at zero.
module branch_target_calc (
    input  logic [31:0] base_addr,
    input  logic [15:0] imm16,
    output logic [31:0] target
);

    logic [31:0] offset_s;

    // Sign-extend the immediate and scale it from words to bytes
    always_comb begin
        offset_s = {{14{imm16[15]}}, imm16, 2'b00};
    end

    // Wrap-around addition; overflow past 2^32 is intentionally dropped
    always_comb begin
        target = base_addr + 32'd4 + offset_s;
    end

endmodule

// File: rtl/instr_fetch_stage.sv
// Fetch stage: owns the PC, drives instruction memory, latches the returned
// word into IR and hands it to decode over valid/ready. Conditional branches
// park the stage until execute reports the outcome.
module instr_fetch_stage
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    output logic [31:0] ir,
    output logic [31:0] ir_pc,
    output logic        ir_valid,
    input  logic        ir_ready,
    input  logic        br_done,
    input  logic        br_taken,
    output logic [31:0] pc,
    output logic        halted
);

    fetch_state_e state_r;
    fetch_state_e state_nxt_s;

    logic [31:0] pc_r;
    logic [31:0] pc_nxt_s;
    logic [31:0] ir_r;
    logic [31:0] ir_nxt_s;
    logic [31:0] ir_pc_r;
    logic [31:0] ir_pc_nxt_s;
    logic        ir_valid_r;
    logic        ir_valid_nxt_s;
    logic        halted_r;
    logic        halted_nxt_s;

    logic [5:0]  fetch_opc_s;
    logic [15:0] fetch_imm_s;
    logic [5:0]  ir_opc_s;
    logic [15:0] ir_imm_s;
    logic [31:0] tgt_base_s;
    logic [15:0] tgt_imm_s;
    logic [31:0] tgt_s;

    // Field extraction from the word arriving from memory and from IR
    always_comb begin
        fetch_opc_s = imem_data[OPC_MSB:OPC_LSB];
        fetch_imm_s = imem_data[IMM_MSB:IMM_LSB];
        ir_opc_s    = ir_r[OPC_MSB:OPC_LSB];
        ir_imm_s    = ir_r[IMM_MSB:IMM_LSB];
    end

    // One adder serves both paths: JMP relative to the fetch PC while
    // fetching, branch correction relative to the latched IR address later
    always_comb begin
        if (state_r == ST_BR_WAIT) begin
            tgt_base_s = ir_pc_r;
            tgt_imm_s  = ir_imm_s;
        end else begin
            tgt_base_s = pc_r;
            tgt_imm_s  = fetch_imm_s;
        end
    end

    branch_target_calc u_target (
        .base_addr (tgt_base_s),
        .imm16     (tgt_imm_s),
        .target    (tgt_s)
    );

    // Next-state and next-datapath logic for the fetch FSM
    always_comb begin
        state_nxt_s    = state_r;
        pc_nxt_s       = pc_r;
        ir_nxt_s       = ir_r;
        ir_pc_nxt_s    = ir_pc_r;
        ir_valid_nxt_s = ir_valid_r;
        halted_nxt_s   = halted_r;

        case (state_r)
            ST_FETCH: begin
                ir_nxt_s       = imem_data;
                ir_pc_nxt_s    = pc_r;
                ir_valid_nxt_s = 1'b1;
                state_nxt_s    = ST_ISSUE;
                if (fetch_opc_s == OPC_JMP) begin
                    pc_nxt_s = tgt_s;
                    if (fetch_imm_s == IMM_SELF_JUMP) begin
                        halted_nxt_s = 1'b1;
                    end else begin
                        halted_nxt_s = halted_r;
                    end
                end else begin
                    pc_nxt_s = pc_r + 32'd4;
                end
            end

            ST_ISSUE: begin
                // IR, its address and PC are held; only the handshake moves us
                if (ir_valid_r && ir_ready) begin
                    ir_valid_nxt_s = 1'b0;
                    if (is_cond_branch(ir_opc_s)) begin
                        state_nxt_s = ST_BR_WAIT;
                    end else begin
                        state_nxt_s = ST_FETCH;
                    end
                end else begin
                    state_nxt_s = ST_ISSUE;
                end
            end

            ST_BR_WAIT: begin
                // PC already holds the fall-through; overwrite only if taken
                if (br_done) begin
                    state_nxt_s = ST_FETCH;
                    if (br_taken) begin
                        pc_nxt_s = tgt_s;
                    end else begin
                        pc_nxt_s = pc_r;
                    end
                end else begin
                    state_nxt_s = ST_BR_WAIT;
                end
            end

            default: begin
                // Unreachable encoding: recover by restarting the fetch
                state_nxt_s = ST_FETCH;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r    <= ST_FETCH;
            pc_r       <= RESET_PC;
            ir_r       <= 32'h0000_0000;
            ir_pc_r    <= 32'h0000_0000;
            ir_valid_r <= 1'b0;
            halted_r   <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            pc_r       <= pc_nxt_s;
            ir_r       <= ir_nxt_s;
            ir_pc_r    <= ir_pc_nxt_s;
            ir_valid_r <= ir_valid_nxt_s;
            halted_r   <= halted_nxt_s;
        end
    end

    // Outputs come straight from registers; the memory address mirrors PC
    always_comb begin
        imem_addr = pc_r;
        pc        = pc_r;
        ir        = ir_r;
        ir_pc     = ir_pc_r;
        ir_valid  = ir_valid_r;
        halted    = halted_r;
    end

endmodule
